// File: rtl/core_bus_router_pkg.sv
// Shared types and constants for core_bus_router and its address decoder.
package core_bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2,
        ST_RESPOND  = 2'd3
    } state_e;

    localparam logic [7:0] INSTR_NOP           = 8'h00;
    localparam logic [7:0] INSTR_STREAM_SELECT = 8'hF0;

    // Wide enough for CORE_LATENCY-1 with latency up to 15.
    localparam int CNT_W  = 4;
    localparam int STAT_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_addr_decoder.sv
// Combinational window decoder: lowest-index core whose [base, base+span) holds addr.
module core_addr_decoder
    import core_bus_router_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 24,
    parameter logic [NUM_CORES*ADDR_WIDTH-1:0] CORE_BASE = '0,
    parameter logic [NUM_CORES*ADDR_WIDTH-1:0] CORE_SPAN = '0,
    localparam int IDX_W = idx_width(NUM_CORES)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx,
    output logic [ADDR_WIDTH-1:0] offset
);

    // Descending scan so the lowest matching index is written last. The upper
    // bound is formed one bit wider so a window never wraps past zero.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (({1'b0, addr} >= {1'b0, CORE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]}) &&
                ({1'b0, addr} <  ({1'b0, CORE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]} +
                                  {1'b0, CORE_SPAN[i*ADDR_WIDTH +: ADDR_WIDTH]}))) begin
                hit    = 1'b1;
                idx    = IDX_W'(i);
                offset = addr - CORE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

endmodule

// File: rtl/core_bus_router.sv
// Routes one request at a time from the instruction handler to one of NUM_CORES cores.
// Optional CORE_BUS_ROUTER_STATS_EN adds saturating dispatch/error counters.
module core_bus_router
    import core_bus_router_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int INSTR_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 32,
    parameter logic [NUM_CORES*ADDR_WIDTH-1:0] CORE_BASE = '0,
    parameter logic [NUM_CORES*ADDR_WIDTH-1:0] CORE_SPAN = '0,
    parameter int CORE_LATENCY = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [INSTR_WIDTH-1:0]           req_instruction,
    input  logic [ADDR_WIDTH-1:0]            req_address,
    input  logic [DATA_WIDTH-1:0]            req_value,
    output logic                             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_value,
    output logic                             resp_error,
    output logic [NUM_CORES*INSTR_WIDTH-1:0] core_instruction,
    output logic [ADDR_WIDTH-1:0]            core_address,
    output logic [DATA_WIDTH-1:0]            core_value,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_output_value,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_stream_bus,
`ifdef CORE_BUS_ROUTER_STATS_EN
    output logic [DATA_WIDTH-1:0]            stream_value,
    output logic [STAT_W-1:0]                stat_dispatch_count,
    output logic [STAT_W-1:0]                stat_error_count
`else
    output logic [DATA_WIDTH-1:0]            stream_value
`endif
);

    // Handshake: a request transfers on a rising clock edge where req_valid and
    // req_ready are both high; req_ready is high only in ST_IDLE and nothing
    // presented in any other state is captured.

    localparam int IDX_W = idx_width(NUM_CORES);

    state_e                  state_q, state_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   core_address_q, core_address_d;
    logic [DATA_WIDTH-1:0]   core_value_q, core_value_d;
    logic [IDX_W-1:0]        stream_sel_q, stream_sel_d;
    logic [DATA_WIDTH-1:0]   stream_value_q, stream_value_d;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic [ADDR_WIDTH-1:0]   dec_offset;

    core_addr_decoder #(
        .NUM_CORES  (NUM_CORES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CORE_BASE  (CORE_BASE),
        .CORE_SPAN  (CORE_SPAN)
    ) u_decoder (
        .addr   (req_address),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_offset)
    );

    always_comb begin
        state_d          = state_q;
        instr_d          = instr_q;
        sel_d            = sel_q;
        err_d            = err_q;
        cnt_d            = cnt_q;
        core_address_d   = core_address_q;
        core_value_d     = core_value_q;
        stream_sel_d     = stream_sel_q;
        stream_value_d   = core_stream_bus[stream_sel_q*DATA_WIDTH +: DATA_WIDTH];
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_error       = 1'b0;
        resp_value       = '0;
        core_instruction = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    instr_d = req_instruction;
                    sel_d   = dec_idx;
                    err_d   = 1'b0;
                    if (req_instruction == INSTR_WIDTH'(INSTR_STREAM_SELECT)) begin
                        state_d = ST_RESPOND;
                        if (req_value < DATA_WIDTH'(NUM_CORES)) begin
                            stream_sel_d = req_value[IDX_W-1:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (!dec_hit) begin
                        state_d = ST_RESPOND;
                        err_d   = 1'b1;
                    end else begin
                        // Core-facing address/value only move for real dispatches.
                        state_d        = ST_DISPATCH;
                        core_address_d = dec_offset;
                        core_value_d   = req_value;
                    end
                end
            end
            ST_DISPATCH: begin
                core_instruction[sel_q*INSTR_WIDTH +: INSTR_WIDTH] = instr_q;
                if (CORE_LATENCY == 0) begin
                    state_d = ST_RESPOND;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(CORE_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_value = err_q ? '0 : core_output_value[sel_q*DATA_WIDTH +: DATA_WIDTH];
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            instr_q        <= '0;
            sel_q          <= '0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
            core_address_q <= '0;
            core_value_q   <= '0;
            stream_sel_q   <= '0;
            stream_value_q <= '0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            sel_q          <= sel_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            core_address_q <= core_address_d;
            core_value_q   <= core_value_d;
            stream_sel_q   <= stream_sel_d;
            stream_value_q <= stream_value_d;
        end
    end

    assign core_address = core_address_q;
    assign core_value   = core_value_q;
    assign stream_value = stream_value_q;

`ifdef CORE_BUS_ROUTER_STATS_EN
    logic [STAT_W-1:0] stat_dispatch_q, stat_dispatch_d;
    logic [STAT_W-1:0] stat_error_q, stat_error_d;

    // Counted on state entry, holding at all-ones once saturated.
    always_comb begin
        stat_dispatch_d = stat_dispatch_q;
        stat_error_d    = stat_error_q;
        if ((state_d == ST_DISPATCH) && (state_q != ST_DISPATCH) && (stat_dispatch_q != '1)) begin
            stat_dispatch_d = stat_dispatch_q + STAT_W'(1);
        end
        if ((state_d == ST_RESPOND) && (state_q != ST_RESPOND) && err_d && (stat_error_q != '1)) begin
            stat_error_d = stat_error_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_dispatch_q <= '0;
            stat_error_q    <= '0;
        end else begin
            stat_dispatch_q <= stat_dispatch_d;
            stat_error_q    <= stat_error_d;
        end
    end

    assign stat_dispatch_count = stat_dispatch_q;
    assign stat_error_count    = stat_error_q;
`else
`endif

endmodule

// File: tb/tb_core_bus_router.sv
// Directed bench for core_bus_router: a latency-2 instance with disjoint windows and a
// latency-0 instance with overlapping, top-of-space and disabled windows.
module tb_core_bus_router;

    localparam int NC = 4;
    localparam int IW = 8;
    localparam int AW = 24;
    localparam int DW = 32;

    localparam logic [NC*AW-1:0] BASE_A = {24'h000030, 24'h000020, 24'h000010, 24'h000000};
    localparam logic [NC*AW-1:0] SPAN_A = {24'h000010, 24'h000010, 24'h000010, 24'h000010};
    localparam logic [NC*AW-1:0] BASE_B = {24'h000040, 24'hFFFFF0, 24'h000010, 24'h000008};
    localparam logic [NC*AW-1:0] SPAN_B = {24'h000000, 24'h000020, 24'h000010, 24'h000020};

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid_a = 1'b0;
    logic              req_valid_b = 1'b0;
    logic [IW-1:0]     req_instruction = '0;
    logic [AW-1:0]     req_address = '0;
    logic [DW-1:0]     req_value = '0;
    logic [NC*DW-1:0]  core_output_value;
    logic [NC*DW-1:0]  core_stream_bus;

    logic              req_ready_a, resp_valid_a, resp_error_a;
    logic [DW-1:0]     resp_value_a, core_value_a, stream_value_a;
    logic [NC*IW-1:0]  core_instruction_a;
    logic [AW-1:0]     core_address_a;
    logic              req_ready_b, resp_valid_b, resp_error_b;
    logic [DW-1:0]     resp_value_b, core_value_b, stream_value_b;
    logic [NC*IW-1:0]  core_instruction_b;
    logic [AW-1:0]     core_address_b;
`ifdef CORE_BUS_ROUTER_STATS_EN
    logic [15:0]       stat_dispatch_a, stat_error_a, stat_dispatch_b, stat_error_b;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    core_bus_router #(
        .NUM_CORES(NC), .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CORE_BASE(BASE_A), .CORE_SPAN(SPAN_A), .CORE_LATENCY(2)
    ) dut_a (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid_a),
        .req_ready         (req_ready_a),
        .req_instruction   (req_instruction),
        .req_address       (req_address),
        .req_value         (req_value),
        .resp_valid        (resp_valid_a),
        .resp_value        (resp_value_a),
        .resp_error        (resp_error_a),
        .core_instruction  (core_instruction_a),
        .core_address      (core_address_a),
        .core_value        (core_value_a),
        .core_output_value (core_output_value),
        .core_stream_bus   (core_stream_bus),
`ifdef CORE_BUS_ROUTER_STATS_EN
        .stream_value        (stream_value_a),
        .stat_dispatch_count (stat_dispatch_a),
        .stat_error_count    (stat_error_a)
`else
        .stream_value      (stream_value_a)
`endif
    );

    core_bus_router #(
        .NUM_CORES(NC), .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CORE_BASE(BASE_B), .CORE_SPAN(SPAN_B), .CORE_LATENCY(0)
    ) dut_b (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid_b),
        .req_ready         (req_ready_b),
        .req_instruction   (req_instruction),
        .req_address       (req_address),
        .req_value         (req_value),
        .resp_valid        (resp_valid_b),
        .resp_value        (resp_value_b),
        .resp_error        (resp_error_b),
        .core_instruction  (core_instruction_b),
        .core_address      (core_address_b),
        .core_value        (core_value_b),
        .core_output_value (core_output_value),
        .core_stream_bus   (core_stream_bus),
`ifdef CORE_BUS_ROUTER_STATS_EN
        .stream_value        (stream_value_b),
        .stat_dispatch_count (stat_dispatch_b),
        .stat_error_count    (stat_error_b)
`else
        .stream_value      (stream_value_b)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver: present one request while the target is idle; returns in cycle 1
    task automatic drive_req(input bit on_b, input logic [7:0] instr,
                             input logic [23:0] addr, input logic [31:0] val);
        check("ready_before_req", 32'(on_b ? req_ready_b : req_ready_a), 32'd1);
        req_instruction = instr;
        req_address     = addr;
        req_value       = val;
        if (on_b) req_valid_b = 1'b1;
        else      req_valid_a = 1'b1;
        step();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic do_dispatch(input bit on_b, input logic [7:0] instr, input logic [23:0] addr,
                               input logic [31:0] val, input int exp_core, input logic [23:0] exp_off);
        int lat;
        logic [31:0] exp_ci;
        lat    = on_b ? 0 : 2;
        exp_ci = 32'(instr) << (8 * exp_core);
        drive_req(on_b, instr, addr, val);
        check("disp_instr",   on_b ? core_instruction_b : core_instruction_a, exp_ci);
        check("disp_addr",    32'(on_b ? core_address_b : core_address_a), 32'(exp_off));
        check("disp_value",   on_b ? core_value_b : core_value_a, val);
        check("disp_ready",   32'(on_b ? req_ready_b : req_ready_a), 32'd0);
        check("disp_rvalid",  32'(on_b ? resp_valid_b : resp_valid_a), 32'd0);
        for (int c = 0; c < lat; c++) begin
            step();
            check("wait_instr",  on_b ? core_instruction_b : core_instruction_a, 32'd0);
            check("wait_rvalid", 32'(on_b ? resp_valid_b : resp_valid_a), 32'd0);
            check("wait_addr",   32'(on_b ? core_address_b : core_address_a), 32'(exp_off));
        end
        step();
        check("resp_valid", 32'(on_b ? resp_valid_b : resp_valid_a), 32'd1);
        check("resp_error", 32'(on_b ? resp_error_b : resp_error_a), 32'd0);
        check("resp_value", on_b ? resp_value_b : resp_value_a, 32'hC0DE_0000 + 32'(exp_core));
        step();
        check("post_ready",  32'(on_b ? req_ready_b : req_ready_a), 32'd1);
        check("post_rvalid", 32'(on_b ? resp_valid_b : resp_valid_a), 32'd0);
    endtask

    task automatic do_error(input bit on_b, input logic [7:0] instr, input logic [23:0] addr,
                            input logic [31:0] val);
        drive_req(on_b, instr, addr, val);
        check("err_rvalid", 32'(on_b ? resp_valid_b : resp_valid_a), 32'd1);
        check("err_flag",   32'(on_b ? resp_error_b : resp_error_a), 32'd1);
        check("err_value",  on_b ? resp_value_b : resp_value_a, 32'd0);
        check("err_instr",  on_b ? core_instruction_b : core_instruction_a, 32'd0);
        step();
        check("err_ready",  32'(on_b ? req_ready_b : req_ready_a), 32'd1);
        check("err_instr2", on_b ? core_instruction_b : core_instruction_a, 32'd0);
    endtask

    int pulses;

    initial begin
        core_output_value = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        core_stream_bus   = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};

        step();
        step();
        check("rst_ready",   32'(req_ready_a), 32'd1);
        check("rst_rvalid",  32'(resp_valid_a), 32'd0);
        check("rst_rvalue",  resp_value_a, 32'd0);
        check("rst_instr",   core_instruction_a, 32'd0);
        check("rst_addr",    32'(core_address_a), 32'd0);
        check("rst_value",   core_value_a, 32'd0);
        check("rst_stream",  stream_value_a, 32'd0);
        reset = 1'b0;
        step();
        check("stream_core0", stream_value_a, 32'h5000_0000);

        // basic dispatch to core 2 with window-relative address
        do_dispatch(1'b0, 8'h01, 24'h000023, 32'hAABB_CCDD, 2, 24'h000003);

        // reset during WAIT while a second request is held on req_valid
        drive_req(1'b0, 8'h05, 24'h000013, 32'h0000_1234);
        req_valid_a     = 1'b1;
        req_instruction = 8'h09;
        req_address     = 24'h000005;
        step();
        check("hold_ready",  32'(req_ready_a), 32'd0);
        check("hold_instr",  core_instruction_a, 32'd0);
        step();
        check("hold_instr2", core_instruction_a, 32'd0);
        check("hold_addr",   32'(core_address_a), 32'h0000_0003);
        #2;
        reset = 1'b1;
        #1;
        check("async_rvalid", 32'(resp_valid_a), 32'd0);
        check("async_ready",  32'(req_ready_a), 32'd1);
        check("async_addr",   32'(core_address_a), 32'd0);
        check("async_value",  core_value_a, 32'd0);
        check("async_instr",  core_instruction_a, 32'd0);
        check("async_stream", stream_value_a, 32'd0);
        req_valid_a = 1'b0;
        step();
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (resp_valid_a) pulses++;
        end
        check("abort_no_resp", 32'(pulses), 32'd0);
        check("abort_ready",   32'(req_ready_a), 32'd1);

        // unmapped address
        do_error(1'b0, 8'h01, 24'h000040, 32'h1111_1111);

        // stream select 3, then tracking and lag
        drive_req(1'b0, 8'hF0, 24'h000000, 32'd3);
        check("sel3_rvalid", 32'(resp_valid_a), 32'd1);
        check("sel3_error",  32'(resp_error_a), 32'd0);
        check("sel3_old",    stream_value_a, 32'h5000_0000);
        step();
        check("sel3_new",    stream_value_a, 32'h5000_0003);
        core_stream_bus[127:96] = 32'h5000_0033;
        check("stream_lag",  stream_value_a, 32'h5000_0003);
        step();
        check("stream_track", stream_value_a, 32'h5000_0033);

        // out-of-range select is rejected and keeps core 3
        do_error(1'b0, 8'hF0, 24'h000000, 32'd4);
        step();
        check("sel4_kept", stream_value_a, 32'h5000_0033);

        // window edges
        do_dispatch(1'b0, 8'h11, 24'h00000F, 32'h0000_00A5, 0, 24'h00000F);
        do_dispatch(1'b0, 8'h22, 24'h000030, 32'h0000_005A, 3, 24'h000000);
        do_dispatch(1'b0, 8'h33, 24'h00003F, 32'hFFFF_FFFF, 3, 24'h00000F);

        // overlap, top-of-space, no-wrap and disabled windows on the latency-0 instance
        do_dispatch(1'b1, 8'h07, 24'h000015, 32'h0000_0077, 0, 24'h00000D);
        do_dispatch(1'b1, 8'h08, 24'hFFFFF8, 32'h0000_0088, 2, 24'h000008);
        do_error(1'b1, 8'h01, 24'h000005, 32'h0000_0000);
        do_error(1'b1, 8'h01, 24'h000045, 32'h0000_0000);

`ifdef CORE_BUS_ROUTER_STATS_EN
        check("stat_disp_a", 32'(stat_dispatch_a), 32'd3);
        check("stat_err_a",  32'(stat_error_a),    32'd2);
        check("stat_disp_b", 32'(stat_dispatch_b), 32'd2);
        check("stat_err_b",  32'(stat_error_b),    32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
